// File: rtl/native2axi_master_if.sv
// AXI4-Lite channel bundle between native2axi_master and an AXI4-Lite slave.
//   master modport : drives aw*/w*/ar* payload+valid, bready, rready
//   slave  modport : drives awready, wready, b*, arready, r*
// ADDR_W/DATA_W must match the bridge's M_AXI_ADDR_WIDTH/M_AXI_DATA_WIDTH.
interface native2axi_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/native2axi_master.sv
// native2axi_master: turns one native request strobe into one AXI4-Lite
// write or read and returns a single-cycle completion pulse.
//   M_AXI_aclk/M_AXI_areset : clock, synchronous active-high reset
//   NATIVE_EN/WR/ADDR/DATA_IN : request, sampled on the EN cycle (idle only)
//   NATIVE_DATA_OUT : last read data, held until the next read completes
//   NATIVE_READY    : one-cycle completion pulse; NATIVE_ERR valid with it
//   NATIVE_BUSY     : high whenever an access is in flight
//   m_axi           : AXI4-Lite master channels (native2axi_master_if.master)
// Optional feature macro NATIVE2AXI_WSTRB_EN: adds NATIVE_BE byte enables
// that drive wstrb; without it wstrb is all-ones.
module native2axi_master #(
  parameter int NATIVE_ADDR_WIDTH = 3,
  parameter int NATIVE_DATA_WIDTH = 32,
  parameter int M_AXI_ADDR_WIDTH  = 5,
  parameter int M_AXI_DATA_WIDTH  = 32
) (
  input  logic                         M_AXI_aclk,
  input  logic                         M_AXI_areset,
  input  logic                         NATIVE_EN,
  input  logic                         NATIVE_WR,
  input  logic [NATIVE_ADDR_WIDTH-1:0] NATIVE_ADDR,
  input  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN,
`ifdef NATIVE2AXI_WSTRB_EN
  input  logic [NATIVE_DATA_WIDTH/8-1:0] NATIVE_BE,
`endif
  output logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT,
  output logic                         NATIVE_READY,
  output logic                         NATIVE_ERR,
  output logic                         NATIVE_BUSY,
  native2axi_master_if.master          m_axi
);

  localparam int STRB_W = M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, W_REQ, W_RESP, R_REQ, R_DATA, DONE} state_t;
  state_t state, state_nx;

  logic [M_AXI_ADDR_WIDTH-1:0]  addr_q;
  logic [NATIVE_DATA_WIDTH-1:0] wdata_q;
  logic                         awvalid_q, wvalid_q, arvalid_q;
  logic                         err_q;
  logic [NATIVE_DATA_WIDTH-1:0] dout_q;
  logic                         aw_ok, w_ok;

  // A write channel is "done" once its valid is already down or is being
  // accepted this cycle; both must be done to leave W_REQ.
  assign aw_ok = ~awvalid_q | m_axi.awready;
  assign w_ok  = ~wvalid_q  | m_axi.wready;

  always_ff @(posedge M_AXI_aclk) begin
    if (M_AXI_areset) state <= IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (NATIVE_EN) state_nx = NATIVE_WR ? W_REQ : R_REQ;
      W_REQ:   if (aw_ok && w_ok) state_nx = W_RESP;
      W_RESP:  if (m_axi.bvalid) state_nx = DONE;
      R_REQ:   if (m_axi.arready) state_nx = R_DATA;
      R_DATA:  if (m_axi.rvalid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request payload: loaded only on an accepted EN so it stays stable while
  // any valid is up; no reset needed since valids gate it.
  always_ff @(posedge M_AXI_aclk) begin
    if (state == IDLE && NATIVE_EN) begin
      addr_q  <= M_AXI_ADDR_WIDTH'({NATIVE_ADDR, 2'b00});
      wdata_q <= NATIVE_DATA_IN;
    end
  end

`ifdef NATIVE2AXI_WSTRB_EN
  logic [STRB_W-1:0] wstrb_q;
  always_ff @(posedge M_AXI_aclk) begin
    if (state == IDLE && NATIVE_EN) wstrb_q <= NATIVE_BE;
  end
  assign m_axi.wstrb = wstrb_q;
`else
  assign m_axi.wstrb = {STRB_W{1'b1}};
`endif

  // Valids, status and read data. Valids drop only on their own handshake.
  always_ff @(posedge M_AXI_aclk) begin
    if (M_AXI_areset) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (NATIVE_EN) begin
            awvalid_q <= NATIVE_WR;
            wvalid_q  <= NATIVE_WR;
            arvalid_q <= ~NATIVE_WR;
          end
        end
        W_REQ: begin
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
        end
        W_RESP: if (m_axi.bvalid) err_q <= (m_axi.bresp != 2'b00);
        R_REQ:  if (m_axi.arready) arvalid_q <= 1'b0;
        R_DATA: if (m_axi.rvalid) begin
          dout_q <= m_axi.rdata;
          err_q  <= (m_axi.rresp != 2'b00);
        end
        // ERR is only meaningful alongside READY; clear it on the way out.
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.bready  = (state == W_RESP);
  assign m_axi.rready  = (state == R_DATA);

  assign NATIVE_DATA_OUT = dout_q;
  assign NATIVE_READY    = (state == DONE);
  assign NATIVE_ERR      = err_q;
  assign NATIVE_BUSY     = (state != IDLE);

endmodule

// File: tb/tb_native2axi_master.sv
// Self-checking bench for native2axi_master: directed cases followed by
// randomized accesses against a configurable-latency AXI4-Lite slave model.
module tb_native2axi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en = 1'b0, wr = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] din = '0;
`ifdef NATIVE2AXI_WSTRB_EN
  logic [3:0]  be = 4'hF;
`endif
  logic [31:0] dout;
  logic        ready, err, busy;

  native2axi_master_if bus();

  native2axi_master dut (
    .M_AXI_aclk      (clk),
    .M_AXI_areset    (rst),
    .NATIVE_EN       (en),
    .NATIVE_WR       (wr),
    .NATIVE_ADDR     (addr),
    .NATIVE_DATA_IN  (din),
`ifdef NATIVE2AXI_WSTRB_EN
    .NATIVE_BE       (be),
`endif
    .NATIVE_DATA_OUT (dout),
    .NATIVE_READY    (ready),
    .NATIVE_ERR      (err),
    .NATIVE_BUSY     (busy),
    .m_axi           (bus)
  );

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // slave configuration (per access)
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  bresp_v, rresp_v;
  logic [31:0] rdata_v;

  // slave state / observations
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_done, w_done, ar_done;
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs, pv_aw, pv_w, pv_ar;
  int n_aw = 0, n_w = 0, n_ar = 0, n_ready = 0, n_br = 0, n_rr = 0, viol = 0;
  int aw_hs_cyc, w_hs_cyc;
  logic [4:0]  got_awaddr, got_araddr;
  logic [31:0] got_wdata;
  logic [3:0]  got_wstrb;
  logic [2:0]  got_awprot, got_arprot;

  // Slave + monitor. Everything changes on negedge; a valid/ready pair seen
  // high here completes at the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
      bus.bresp = 0; bus.rresp = 0; bus.rdata = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_done = 0; w_done = 0; ar_done = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      pv_aw = 0; pv_w = 0; pv_ar = 0;
    end else begin
      if (pv_aw && !aw_hs && !bus.awvalid) viol++;
      if (pv_w  && !w_hs  && !bus.wvalid)  viol++;
      if (pv_ar && !ar_hs && !bus.arvalid) viol++;
      if (ready) n_ready++;
      if (bus.bready) n_br++;
      if (bus.rready) n_rr++;
      if (aw_hs) begin aw_done = 1; n_aw++; aw_hs_cyc = cyc; bus.awready = 0; aw_cnt = 0; end
      else if (bus.awvalid) begin
        if (aw_cnt >= aw_dly) begin
          bus.awready = 1; got_awaddr = bus.awaddr; got_awprot = bus.awprot;
        end else aw_cnt++;
      end
      if (w_hs) begin w_done = 1; n_w++; w_hs_cyc = cyc; bus.wready = 0; w_cnt = 0; end
      else if (bus.wvalid) begin
        if (w_cnt >= w_dly) begin
          bus.wready = 1; got_wdata = bus.wdata; got_wstrb = bus.wstrb;
        end else w_cnt++;
      end
      if (b_hs) begin bus.bvalid = 0; b_cnt = 0; aw_done = 0; w_done = 0; end
      else if (aw_done && w_done && !bus.bvalid) begin
        if (b_cnt >= b_dly) begin bus.bvalid = 1; bus.bresp = bresp_v; end else b_cnt++;
      end
      if (ar_hs) begin ar_done = 1; n_ar++; bus.arready = 0; ar_cnt = 0; end
      else if (bus.arvalid) begin
        if (ar_cnt >= ar_dly) begin
          bus.arready = 1; got_araddr = bus.araddr; got_arprot = bus.arprot;
        end else ar_cnt++;
      end
      if (r_hs) begin bus.rvalid = 0; r_cnt = 0; ar_done = 0; end
      else if (ar_done && !bus.rvalid) begin
        if (r_cnt >= r_dly) begin
          bus.rvalid = 1; bus.rdata = rdata_v; bus.rresp = rresp_v;
        end else r_cnt++;
      end
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      b_hs  = bus.bvalid && bus.bready;
      ar_hs = bus.arvalid && bus.arready;
      r_hs  = bus.rvalid && bus.rready;
      pv_aw = bus.awvalid; pv_w = bus.wvalid; pv_ar = bus.arvalid;
    end
  end

  // reference: last completed read data (cleared by reset)
  logic [31:0] exp_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slave(input int a, input int w, input int b, input int ar, input int r,
                           input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    bresp_v = br; rresp_v = rr; rdata_v = rd;
  endtask

  // One native access. inj>0 pulses a stray EN on that wait cycle;
  // done_en drives EN during the READY cycle. Both must be ignored.
  task automatic do_txn(input bit w, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int inj, input bit done_en);
    int t0, n, busy_low, lat_exp, nr0, naw0, nw0, nar0, nbr0, nrr0;
    logic [1:0] resp;
    logic [3:0] exp_strb;
`ifdef NATIVE2AXI_WSTRB_EN
    exp_strb = b;
`else
    exp_strb = 4'hF;
`endif
    nr0 = n_ready; naw0 = n_aw; nw0 = n_w; nar0 = n_ar; nbr0 = n_br; nrr0 = n_rr;
    got_awaddr = 'x; got_araddr = 'x; got_wdata = 'x; got_wstrb = 'x;
    en = 1; wr = w; addr = a; din = d;
`ifdef NATIVE2AXI_WSTRB_EN
    be = b;
`endif
    t0 = cyc;
    @(posedge clk); #1;
    en = 0; din = $urandom; addr = 3'($urandom);
    n = 0; busy_low = 0;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
      if (busy !== 1'b1) busy_low++;
      if (inj > 0) begin en = (n == inj); wr = !w; end
    end
    if (done_en) begin en = 1; wr = 0; end else en = 0;
    chk("ready_seen", 32'(ready), 32'd1);
    lat_exp = w ? 3 + (aw_dly > w_dly ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
    chk("latency", 32'(cyc - t0), 32'(lat_exp));
    resp = w ? bresp_v : rresp_v;
    chk("err", 32'(err), 32'(resp != 2'b00));
    if (!w) exp_dout = rdata_v;
    chk("dout", dout, exp_dout);
    chk("busy_throughout", 32'(busy_low), 32'd0);
    @(posedge clk); #1;
    en = 0;
    chk("ready_one_cycle", 32'(ready), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
    chk("dout_hold", dout, exp_dout);
    repeat (2) @(posedge clk); #1;
    chk("busy_stays_low", 32'(busy), 32'd0);
    chk("ready_count", 32'(n_ready - nr0), 32'd1);
    chk("aw_hs_count", 32'(n_aw - naw0), 32'(w));
    chk("w_hs_count", 32'(n_w - nw0), 32'(w));
    chk("ar_hs_count", 32'(n_ar - nar0), 32'(!w));
    if (w) begin
      chk("awaddr", 32'(got_awaddr), 32'({a, 2'b00}));
      chk("awprot", 32'(got_awprot), 32'd0);
      chk("wdata", got_wdata, d);
      chk("wstrb", 32'(got_wstrb), 32'(exp_strb));
      chk("aw_w_skew", 32'(aw_hs_cyc - w_hs_cyc), 32'(aw_dly - w_dly));
      chk("bready_cycles", 32'(n_br - nbr0), 32'(b_dly + 1));
    end else begin
      chk("araddr", 32'(got_araddr), 32'({a, 2'b00}));
      chk("arprot", 32'(got_arprot), 32'd0);
      chk("rready_cycles", 32'(n_rr - nrr0), 32'(r_dly + 1));
    end
  endtask

  initial begin
    int nr0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    rst = 1;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid}), 32'd0);
    chk("rst_readies", 32'({bus.bready, bus.rready}), 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // zero-wait write and read, then a write that must not touch DATA_OUT
    do_txn(1, 3'd3, 32'hA5A5_0001, 4'hF, 0, 0);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h1234_5678);
    do_txn(0, 3'd5, 32'h0, 4'hF, 0, 0);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEAD_BEEF);
    do_txn(1, 3'd1, 32'h0BAD_F00D, 4'hF, 0, 0);

    // skewed write channels, both orders
    set_slave(4, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_txn(1, 3'd6, 32'h1111_2222, 4'hF, 0, 0);
    set_slave(0, 3, 1, 0, 0, 2'b00, 2'b00, 32'h0);
    do_txn(1, 3'd7, 32'h3333_4444, 4'hF, 0, 0);

    // error responses and a slow read
    set_slave(0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0);
    do_txn(1, 3'd2, 32'h5555_6666, 4'hF, 0, 0);
    set_slave(0, 0, 0, 0, 6, 2'b00, 2'b00, 32'h7777_8888);
    do_txn(0, 3'd4, 32'h0, 4'hF, 0, 0);
    set_slave(0, 0, 0, 1, 0, 2'b00, 2'b11, 32'h9999_AAAA);
    do_txn(0, 3'd0, 32'h0, 4'hF, 0, 0);

    // EN while busy, EN in the completion cycle
    set_slave(0, 0, 3, 0, 0, 2'b00, 2'b00, 32'h0);
    do_txn(1, 3'd3, 32'hCCCC_DDDD, 4'hF, 2, 0);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_txn(1, 3'd5, 32'hEEEE_FFFF, 4'hF, 0, 1);

    // reset while waiting for read data
    set_slave(0, 0, 0, 0, 10, 2'b00, 2'b00, 32'hCAFE_F00D);
    en = 1; wr = 0; addr = 3'd2;
    @(posedge clk); #1;
    en = 0;
    repeat (4) @(posedge clk); #1;
    chk("pre_rst_rready", 32'(bus.rready), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_dout = '0;
    chk("mid_rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("mid_rst_rready", 32'(bus.rready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dout", dout, exp_dout);
    nr0 = n_ready;
    repeat (15) @(posedge clk); #1;
    chk("mid_rst_no_ready", 32'(n_ready - nr0), 32'd0);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0F0F_1234);
    do_txn(0, 3'd6, 32'h0, 4'hF, 0, 0);

    // byte enables (fixed all-ones unless the feature is built in)
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_txn(1, 3'd1, 32'h0102_0304, 4'b0110, 0, 0);

    // randomized accesses
    for (int i = 0; i < 24; i++) begin
      set_slave($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 4),
                ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, $urandom);
      do_txn(1'($urandom), 3'($urandom), $urandom, 4'($urandom), 0, 0);
    end

    chk("valid_drop_violations", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
